// File: rtl/lenet_pkg.sv
// Shared definitions for the LeNet layer control units: FSM encoding and
// frame-geometry helpers used to size addresses and the line FIFO.
package lenet_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_READ    = 2'd1,
    ST_DRAIN   = 2'd2,
    ST_HANDOFF = 2'd3
  } cu_state_t;

  // Output frame side for a stride-1 valid convolution.
  function automatic int calc_ofm_size(input int ifm_size, input int kernal_size);
    return ifm_size - kernal_size + 1;
  endfunction

  // Pixels that must be buffered before the first full KxK window exists.
  function automatic int calc_fifo_size(input int ifm_size, input int kernal_size);
    return (kernal_size - 1) * ifm_size + kernal_size;
  endfunction

endpackage

// File: rtl/delay_line.sv
// Fixed-depth shift register, cleared by reset; used to align the OFM write
// enable with the end of the convolution datapath pipeline.
module delay_line #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data
);

  logic [WIDTH-1:0] r_pipe [DEPTH];

  // Shift the input through DEPTH register stages.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_pipe[i] <= {WIDTH{1'b0}};
      end
    end else begin
      r_pipe[0] <= i_data;
      for (int i = 1; i < DEPTH; i++) begin
        r_pipe[i] <= r_pipe[i-1];
      end
    end
  end

  assign o_data = r_pipe[DEPTH-1];

endmodule

// File: rtl/conv2_cu.sv
// Control unit for the conv layer after Pool1: reads one IFM frame from the
// ping-pong buffer, strobes the conv window, writes the OFM and hands each
// finished bank downstream.
module conv2_cu
  import lenet_pkg::*;
#(
  parameter int IFM_SIZE         = 14,
  parameter int IFM_DEPTH        = 6,
  parameter int KERNAL_SIZE      = 5,
  parameter int CONV_LATENCY     = 4,
  parameter int OFM_SIZE         = calc_ofm_size(IFM_SIZE, KERNAL_SIZE),
  parameter int ADDRESS_SIZE_IFM = $clog2(IFM_SIZE * IFM_SIZE),
  parameter int ADDRESS_SIZE_OFM = $clog2(OFM_SIZE * OFM_SIZE)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start_from_previous,
  output logic                        end_to_previous,
  output logic                        ifm_enable_read,
  output logic [ADDRESS_SIZE_IFM-1:0] ifm_address_read,
  output logic                        ifm_sel_read,
  output logic                        fifo_enable,
  output logic                        conv_enable,
  output logic                        ofm_enable_write,
  output logic [ADDRESS_SIZE_OFM-1:0] ofm_address_write,
  output logic                        ofm_sel_write,
  input  logic                        end_from_next,
  output logic                        start_to_next
);

  localparam int FIFO_SIZE = calc_fifo_size(IFM_SIZE, KERNAL_SIZE);
  localparam int CNT_W     = $clog2(IFM_SIZE);
  localparam int AI        = ADDRESS_SIZE_IFM;
  localparam int AO        = ADDRESS_SIZE_OFM;

  // Reject geometries the control timing cannot support.
  if (CONV_LATENCY < 1 || IFM_DEPTH < 1 || KERNAL_SIZE < 1 ||
      FIFO_SIZE > IFM_SIZE * IFM_SIZE) begin : g_param_check
    $error("conv2_cu: illegal parameter combination");
  end

  cu_state_t          r_state;
  cu_state_t          w_next_state;
  logic               w_start_next;
  logic [AI-1:0]      r_ifm_addr;
  logic               r_ifm_sel;
  logic               r_fifo_en;
  logic [CNT_W-1:0]   r_row;
  logic [CNT_W-1:0]   r_col;
  logic               r_conv_en;
  logic               w_ofm_we;
  logic [AO-1:0]      r_ofm_addr;
  logic               r_ofm_sel;
  logic               w_last_read;
  logic               w_last_write;

  assign w_last_read  = (r_state == ST_READ) && (r_ifm_addr == AI'(IFM_SIZE * IFM_SIZE - 1));
  assign w_last_write = w_ofm_we && (r_ofm_addr == AO'(OFM_SIZE * OFM_SIZE - 1));

  // Next-state logic; the downstream start pulse is issued directly from
  // HANDOFF so a waiting bank is released in the same cycle end_from_next rises.
  always_comb begin
    w_next_state = r_state;
    w_start_next = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start_from_previous) w_next_state = ST_READ;
        else                     w_next_state = ST_IDLE;
      end
      ST_READ: begin
        if (w_last_read) w_next_state = ST_DRAIN;
        else             w_next_state = ST_READ;
      end
      ST_DRAIN: begin
        if (w_last_write) w_next_state = ST_HANDOFF;
        else              w_next_state = ST_DRAIN;
      end
      ST_HANDOFF: begin
        if (end_from_next) begin
          w_start_next = 1'b1;
          w_next_state = ST_IDLE;
        end else begin
          w_next_state = ST_HANDOFF;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next_state;
  end

  // IFM raster read address and bank select; the bank flips with the last read.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ifm_addr <= {AI{1'b0}};
      r_ifm_sel  <= 1'b0;
    end else if (r_state == ST_READ) begin
      if (w_last_read) begin
        r_ifm_addr <= {AI{1'b0}};
        r_ifm_sel  <= ~r_ifm_sel;
      end else begin
        r_ifm_addr <= r_ifm_addr + AI'(1);
      end
    end
  end

  // Read data arrives one cycle after the enable; that is when the FIFO shifts.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_fifo_en <= 1'b0;
    else       r_fifo_en <= (r_state == ST_READ);
  end

  // Track the row/column of the pixel entering the FIFO this cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_row <= {CNT_W{1'b0}};
      r_col <= {CNT_W{1'b0}};
    end else if (r_fifo_en) begin
      if (r_col == CNT_W'(IFM_SIZE - 1)) begin
        r_col <= {CNT_W{1'b0}};
        if (r_row == CNT_W'(IFM_SIZE - 1)) r_row <= {CNT_W{1'b0}};
        else                               r_row <= r_row + CNT_W'(1);
      end else begin
        r_col <= r_col + CNT_W'(1);
      end
    end
  end

  // A full window exists once the incoming pixel is at or past (K-1, K-1).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_conv_en <= 1'b0;
    else       r_conv_en <= r_fifo_en &&
                            (r_row >= CNT_W'(KERNAL_SIZE - 1)) &&
                            (r_col >= CNT_W'(KERNAL_SIZE - 1));
  end

  delay_line #(
    .WIDTH (1),
    .DEPTH (CONV_LATENCY)
  ) u_we_pipe (
    .clk    (clk),
    .reset  (reset),
    .i_data (r_conv_en),
    .o_data (w_ofm_we)
  );

  // OFM raster write address, wrapping after the last output pixel.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ofm_addr <= {AO{1'b0}};
    end else if (w_ofm_we) begin
      if (w_last_write) r_ofm_addr <= {AO{1'b0}};
      else              r_ofm_addr <= r_ofm_addr + AO'(1);
    end
  end

  // OFM bank flips when the finished bank is handed downstream.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)             r_ofm_sel <= 1'b0;
    else if (w_start_next) r_ofm_sel <= ~r_ofm_sel;
  end

  assign end_to_previous   = (r_state == ST_IDLE);
  assign ifm_enable_read   = (r_state == ST_READ);
  assign ifm_address_read  = r_ifm_addr;
  assign ifm_sel_read      = r_ifm_sel;
  assign fifo_enable       = r_fifo_en;
  assign conv_enable       = r_conv_en;
  assign ofm_enable_write  = w_ofm_we;
  assign ofm_address_write = r_ofm_addr;
  assign ofm_sel_write     = r_ofm_sel;
  assign start_to_next     = w_start_next;

endmodule
